// File: rtl/hdma_copy_engine.sv
// hdma_copy_engine: HDMA/GDMA byte mover, reads each source byte from the system bus and writes it into VRAM
//  clk, reset        : clock, synchronous active-high reset
//  hdma_rd           : transfer active, qualifies hdma_source_addr/hdma_target_addr
//  bus_rd, bus_addr  : one-cycle read strobe and its address
//  bus_din           : read data, sampled RD_LAT cycles after the bus_rd cycle
//  vram_we/addr/dout : registered one-cycle VRAM write
//  cpu_stall         : CPU hold while a transfer or its drain is in progress
//  bytes_done        : bytes written since the last hdma_rd rise
module hdma_copy_engine #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hdma_rd,
  input  logic [15:0] hdma_source_addr,
  input  logic [15:0] hdma_target_addr,
  output logic        bus_rd,
  output logic [15:0] bus_addr,
  input  logic [7:0]  bus_din,
  output logic        vram_we,
  output logic [12:0] vram_addr,
  output logic [7:0]  vram_dout,
  output logic        cpu_stall,
  output logic [11:0] bytes_done
);
  logic phase, rd_q, issue, inv;
  logic [RD_LAT:0] pv, pi;
  logic [12:0] pt [RD_LAT+1];
  assign issue = hdma_rd & ~phase;
  // VRAM itself and 0xE000+ (echo/OAM/IO/HRAM) are not readable sources
  assign inv = hdma_source_addr[15:13] == 3'b100 || hdma_source_addr[15:13] == 3'b111;
  assign cpu_stall = hdma_rd | bus_rd | (|pv) | vram_we;
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= 1'b0;
      rd_q <= 1'b0;
      pv <= '0;
      bus_rd <= 1'b0;
      bus_addr <= '0;
      vram_we <= 1'b0;
      vram_addr <= '0;
      vram_dout <= '0;
      bytes_done <= '0;
    end else begin
      phase <= issue;
      rd_q <= hdma_rd;
      bus_rd <= issue & ~inv;
      if (issue & ~inv) bus_addr <= hdma_source_addr;
      // stage k is valid in cycle N+1+k; the last stage lines up with bus_din
      pv <= {pv[RD_LAT-1:0], issue};
      pi <= {pi[RD_LAT-1:0], inv};
      pt[0] <= hdma_target_addr[12:0];
      for (int i = 1; i <= RD_LAT; i++) pt[i] <= pt[i-1];
      vram_we <= pv[RD_LAT];
      if (pv[RD_LAT]) begin
        vram_addr <= pt[RD_LAT];
        vram_dout <= pi[RD_LAT] ? 8'hFF : bus_din;
      end
      // a write landing on the rise cycle counts toward the new block
      bytes_done <= (hdma_rd & ~rd_q) ? 12'(vram_we) : bytes_done + 12'(vram_we);
    end
  end
endmodule

// File: tb/tb_hdma_copy_engine.sv
// tb_hdma_copy_engine: directed checks of hdma_copy_engine with RD_LAT=1 and RD_LAT=3 instances
module tb_hdma_copy_engine;
  logic clk = 1'b0, reset = 1'b1, hdma_rd = 1'b0;
  logic [15:0] src = '0, tgt = '0;
  logic bus_rd, vram_we, cpu_stall, bus_rd3, vram_we3, cpu_stall3;
  logic [15:0] bus_addr, bus_addr3, a1, b1, b2, b3;
  logic [12:0] vram_addr, vram_addr3;
  logic [7:0] vram_dout, vram_dout3;
  logic [11:0] bytes_done, bytes_done3;
  int cyc = 0, nw = 0, nw3 = 0, nrd = 0, fall = 0, checks = 0, fails = 0;
  logic pst = 1'b0;
  logic [12:0] wa [512];
  logic [7:0] wd [512];
  int wc [512];
  int wc3 [512];
  always #5 clk = ~clk;
  hdma_copy_engine #(.RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .hdma_rd(hdma_rd), .hdma_source_addr(src), .hdma_target_addr(tgt),
    .bus_rd(bus_rd), .bus_addr(bus_addr), .bus_din(a1[7:0]), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_dout(vram_dout), .cpu_stall(cpu_stall), .bytes_done(bytes_done));
  hdma_copy_engine #(.RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .hdma_rd(hdma_rd), .hdma_source_addr(src), .hdma_target_addr(tgt),
    .bus_rd(bus_rd3), .bus_addr(bus_addr3), .bus_din(b3[7:0]), .vram_we(vram_we3), .vram_addr(vram_addr3),
    .vram_dout(vram_dout3), .cpu_stall(cpu_stall3), .bytes_done(bytes_done3));
  // bus model: data = low byte of the address read RD_LAT cycles earlier
  always @(posedge clk) begin
    cyc <= cyc + 1;
    a1 <= bus_addr;
    b1 <= bus_addr3;
    b2 <= b1;
    b3 <= b2;
  end
  always @(negedge clk) begin
    if (!reset) begin
      if (vram_we) begin
        wa[nw] = vram_addr;
        wd[nw] = vram_dout;
        wc[nw] = cyc;
        nw++;
      end
      if (vram_we3) begin
        wc3[nw3] = cyc;
        nw3++;
      end
      if (bus_rd) nrd++;
      if (pst && !cpu_stall) fall = cyc;
    end
    pst = cpu_stall;
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  initial begin
    int c0, base, base3, rbase;
    step(3);
    chk("rst_bus_rd", 32'(bus_rd), 0);
    chk("rst_bus_addr", 32'(bus_addr), 0);
    chk("rst_vram_we", 32'(vram_we), 0);
    chk("rst_vram_addr", 32'(vram_addr), 0);
    chk("rst_vram_dout", 32'(vram_dout), 0);
    chk("rst_stall", 32'(cpu_stall), 0);
    chk("rst_bytes", 32'(bytes_done), 0);
    reset = 1'b0;
    step(2);
    // GDMA 32 bytes
    base = nw; base3 = nw3; rbase = nrd; c0 = cyc;
    hdma_rd = 1'b1; src = 16'h2040; tgt = 16'h8200;
    #1;
    chk("stall_rise", 32'(cpu_stall), 1);
    for (int k = 0; k < 64; k++) begin
      src = 16'h2040 + 16'(k / 2);
      tgt = 16'h8200 + 16'(k / 2);
      step(1);
    end
    hdma_rd = 1'b0;
    step(10);
    chk("gdma_reads", 32'(nrd - rbase), 32);
    chk("gdma_writes", 32'(nw - base), 32);
    chk("gdma_addr0", 32'(wa[base]), 32'h200);
    chk("gdma_data0", 32'(wd[base]), 32'h40);
    chk("gdma_addr31", 32'(wa[base+31]), 32'h21F);
    chk("gdma_data31", 32'(wd[base+31]), 32'h5F);
    chk("gdma_data17", 32'(wd[base+17]), 32'h51);
    chk("lat1_first", 32'(wc[base] - c0), 3);
    chk("lat3_first", 32'(wc3[base3] - c0), 5);
    chk("lat3_writes", 32'(nw3 - base3), 32);
    chk("gdma_bytes", 32'(bytes_done), 32);
    chk("lat3_bytes", 32'(bytes_done3), 32);
    chk("stall_fall", 32'(fall - wc[base+31]), 1);
    // invalid sources
    base = nw; rbase = nrd;
    hdma_rd = 1'b1; src = 16'h8000; tgt = 16'h8010;
    step(2);
    src = 16'hE000; tgt = 16'h8011;
    step(2);
    hdma_rd = 1'b0;
    step(8);
    chk("inv_reads", 32'(nrd - rbase), 0);
    chk("inv_writes", 32'(nw - base), 2);
    chk("inv_data0", 32'(wd[base]), 32'hFF);
    chk("inv_data1", 32'(wd[base+1]), 32'hFF);
    chk("inv_addr1", 32'(wa[base+1]), 32'h011);
    chk("inv_bytes", 32'(bytes_done), 2);
    // cancel after 5 cycles
    base = nw; base3 = nw3;
    hdma_rd = 1'b1;
    for (int k = 0; k < 5; k++) begin
      src = 16'h1000 + 16'(k / 2);
      tgt = 16'h9000 + 16'(k / 2);
      step(1);
    end
    hdma_rd = 1'b0;
    step(10);
    chk("cancel_writes", 32'(nw - base), 3);
    chk("cancel_writes3", 32'(nw3 - base3), 3);
    chk("cancel_addr", 32'(wa[base+2]), 32'h1002);
    chk("cancel_data", 32'(wd[base+2]), 32'h02);
    chk("cancel_bytes", 32'(bytes_done), 3);
    // reset one cycle after an issue
    base = nw;
    hdma_rd = 1'b1; src = 16'h3000; tgt = 16'h8300;
    step(1);
    chk("pre_rst_bus_rd", 32'(bus_rd), 1);
    reset = 1'b1; hdma_rd = 1'b0;
    step(1);
    chk("mid_rst_bus_rd", 32'(bus_rd), 0);
    chk("mid_rst_stall", 32'(cpu_stall), 0);
    chk("mid_rst_bytes", 32'(bytes_done), 0);
    chk("mid_rst_addr", 32'(bus_addr), 0);
    reset = 1'b0;
    step(8);
    chk("mid_rst_writes", 32'(nw - base), 0);
    // back-to-back blocks
    base = nw;
    hdma_rd = 1'b1; src = 16'h4001; tgt = 16'h8100;
    step(2);
    hdma_rd = 1'b0;
    step(1);
    hdma_rd = 1'b1; src = 16'h4002; tgt = 16'h8101;
    chk("b2b_we", 32'(vram_we), 1);
    step(1);
    chk("b2b_bytes", 32'(bytes_done), 1);
    step(1);
    hdma_rd = 1'b0;
    step(8);
    chk("b2b_writes", 32'(nw - base), 2);
    chk("b2b_data0", 32'(wd[base]), 32'h01);
    chk("b2b_data1", 32'(wd[base+1]), 32'h02);
    chk("b2b_addr1", 32'(wa[base+1]), 32'h101);
    chk("b2b_bytes_end", 32'(bytes_done), 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
